// File: rtl/grf_mp.sv
// Multi-ported register file: two write ports with port-1 priority, NR combinational
// read ports with same-cycle forwarding, and a pending-write scoreboard with popcount.
module grf_mp #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we0,
    input  logic             we1,
    input  logic [AW-1:0]    wa0,
    input  logic [AW-1:0]    wa1,
    input  logic [DW-1:0]    wd0,
    input  logic [DW-1:0]    wd1,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_addr,
    input  logic [NR*AW-1:0] ra,
    output logic [NR*DW-1:0] rd,
    output logic [NR-1:0]    rbusy,
    output logic [AW:0]      busy_cnt
);

    localparam int DEPTH = 1 << AW;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    logic             we0_eff;
    logic             we1_eff;
    logic             iss_eff;

    logic [AW-1:0]    ra_k;
    logic [DW-1:0]    data_k;
    logic             hit0;
    logic             hit1;
    logic             hit_iss;

    // Register 0 is hardwired when ZERO_REG is set, so writes and issues to it are dropped here.
    assign we0_eff = we0 && !(ZR && (wa0 == '0));
    assign we1_eff = we1 && !(ZR && (wa1 == '0));
    assign iss_eff = iss_en && !(ZR && (iss_addr == '0));

    // Writes retire pending bits; an issue applied afterwards wins on a shared address.
    always_comb begin
        pend_nxt = pend;
        if (we0_eff) begin
            pend_nxt[wa0] = 1'b0;
        end
        if (we1_eff) begin
            pend_nxt[wa1] = 1'b0;
        end
        if (iss_eff) begin
            pend_nxt[iss_addr] = 1'b1;
        end
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pend     <= '0;
            busy_cnt <= '0;
        end else begin
            if (we0_eff) begin
                mem[wa0] <= wd0;
            end
            // Issued after port 0 so a same-address collision stores wd1.
            if (we1_eff) begin
                mem[wa1] <= wd1;
            end
            pend     <= pend_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read ports: forward this cycle's write data (port 1 first), else stored contents.
    always_comb begin
        rd      = '0;
        rbusy   = '0;
        ra_k    = '0;
        data_k  = '0;
        hit0    = 1'b0;
        hit1    = 1'b0;
        hit_iss = 1'b0;
        for (int k = 0; k < NR; k++) begin
            ra_k    = ra[k*AW +: AW];
            hit0    = we0_eff && (wa0 == ra_k);
            hit1    = we1_eff && (wa1 == ra_k);
            hit_iss = iss_eff && (iss_addr == ra_k);
            if (hit1) begin
                data_k = wd1;
            end else if (hit0) begin
                data_k = wd0;
            end else begin
                data_k = mem[ra_k];
            end
            if (ZR && (ra_k == '0)) begin
                data_k = '0;
            end
            rd[k*DW +: DW] = data_k;
            rbusy[k]       = pend[ra_k] && !((hit0 || hit1) && !hit_iss);
        end
    end

endmodule

// File: tb/tb_grf_mp.sv
// Directed scoreboard bench for grf_mp: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the live outputs.
module tb_grf_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             we0, we1;
    logic [AW-1:0]    wa0, wa1;
    logic [DW-1:0]    wd0, wd1;
    logic             iss_en;
    logic [AW-1:0]    iss_addr;
    logic [AW-1:0]    ra0, ra1;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic [AW:0]      busy_cnt;

    int compared   = 0;
    int mismatched = 0;

    string       name_q[$];
    int          kind_q[$];
    logic [31:0] exp_q[$];

    assign ra = {ra1, ra0};

    grf_mp #(.DW(DW), .AW(AW), .NR(NR), .ZERO_REG(1)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .we0      (we0),
        .we1      (we1),
        .wa0      (wa0),
        .wa1      (wa1),
        .wd0      (wd0),
        .wd1      (wd1),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = rd port 0, 1 = rd port 1, 2 = rbusy, 3 = busy_cnt
    task automatic chk(input string n, input int kind, input logic [31:0] e);
        name_q.push_back(n);
        kind_q.push_back(kind);
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0    = 1'b0;
        we1    = 1'b0;
        iss_en = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        string       n;
        int          k;
        logic [31:0] e;
        logic [31:0] act;
        while (kind_q.size() > 0) begin
            n = name_q.pop_front();
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            case (k)
                0:       act = rd[31:0];
                1:       act = rd[63:32];
                2:       act = {30'd0, rbusy};
                default: act = {26'd0, busy_cnt};
            endcase
            compared++;
            if (act !== e) begin
                mismatched++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
        iss_en = 1'b0; iss_addr = '0; ra0 = '0; ra1 = '0;

        step; ra0 = 5'd5; ra1 = 5'd31;
        chk("in_reset_cnt", 3, 32'd0);
        step; reset_n = 1'b1;
        chk("post_rst_rd0", 0, 32'd0);
        chk("post_rst_rd1", 1, 32'd0);
        chk("post_rst_rbusy", 2, 32'd0);
        chk("post_rst_cnt", 3, 32'd0);

        step; we0 = 1; wa0 = 5'd3; wd0 = 32'h1111; we1 = 1; wa1 = 5'd3; wd1 = 32'h2222; ra0 = 5'd3;
        chk("collide_fwd", 0, 32'h2222);
        step; idle;
        chk("collide_stored", 0, 32'h2222);

        step; we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF_FFFF; ra0 = 5'd0;
        chk("zero_fwd", 0, 32'd0);
        step; idle;
        chk("zero_stored", 0, 32'd0);

        step; we0 = 1; wa0 = 5'd10; wd0 = 32'hA5A5; ra0 = 5'd3; ra1 = 5'd10;
        chk("p0_fwd", 1, 32'hA5A5);
        chk("p0_other_port", 0, 32'h2222);
        step; idle;
        chk("p0_stored", 1, 32'hA5A5);

        step; iss_en = 1; iss_addr = 5'd7;
        chk("iss7_cnt_before", 3, 32'd0);
        step; iss_addr = 5'd9; ra0 = 5'd7; ra1 = 5'd3;
        chk("iss7_cnt", 3, 32'd1);
        chk("iss7_rbusy", 2, 32'b01);
        step; iss_addr = 5'd7; we0 = 1; wa0 = 5'd7; wd0 = 32'h77; ra0 = 5'd7; ra1 = 5'd9;
        chk("iss9_cnt", 3, 32'd2);
        chk("iss_wr_same_rbusy", 2, 32'b11);
        step; idle; we0 = 1; wa0 = 5'd9; wd0 = 32'h99; ra0 = 5'd9; ra1 = 5'd7;
        chk("set_wins_cnt", 3, 32'd2);
        chk("wr9_rbusy", 2, 32'b10);
        chk("wr9_fwd", 0, 32'h99);
        step; idle; iss_en = 1; iss_addr = 5'd7;
        chk("wr9_cnt", 3, 32'd1);
        chk("reiss_rbusy", 2, 32'b10);
        chk("rd7_stored", 1, 32'h77);
        step; idle; iss_en = 1; iss_addr = 5'd0; ra0 = 5'd0;
        chk("reiss_cnt", 3, 32'd1);
        step; idle; we0 = 1; wa0 = 5'd7; wd0 = 32'h70;
        chk("iss0_cnt", 3, 32'd1);
        chk("wr7_rbusy", 2, 32'b00);

        step; idle; iss_en = 1; iss_addr = 5'd4;
        chk("clr7_cnt", 3, 32'd0);
        step; idle; we1 = 1; wa1 = 5'd4; wd1 = 32'hABCD; ra1 = 5'd4;
        chk("wr4_rbusy", 2, 32'b00);
        chk("wr4_fwd", 1, 32'hABCD);
        chk("iss4_cnt", 3, 32'd1);
        step; idle; we0 = 1; wa0 = 5'd12; wd0 = 32'h1234; ra0 = 5'd12;
        chk("wr4_cnt", 3, 32'd0);
        chk("wr12_fwd", 0, 32'h1234);
        step; idle; ra1 = 5'd7;
        chk("plain_wr_cnt", 3, 32'd0);
        chk("rd7_new", 1, 32'h70);

        step; we0 = 1; wa0 = 5'd2; wd0 = 32'h55; iss_en = 1; iss_addr = 5'd6; ra0 = 5'd2;
        chk("wr2_fwd", 0, 32'h55);
        step; idle;
        chk("wr2_stored", 0, 32'h55);
        chk("iss6_cnt", 3, 32'd1);
        step; reset_n = 1'b0;
        chk("async_rst_rd0", 0, 32'd0);
        chk("async_rst_rd1", 1, 32'd0);
        chk("async_rst_cnt", 3, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        step; reset_n = 1'b0; we0 = 1; wa0 = 5'd8; wd0 = 32'hDEAD; iss_en = 1; iss_addr = 5'd8; ra0 = 5'd8;
        step;
        chk("held_rst_cnt", 3, 32'd0);
        step; idle; reset_n = 1'b1;
        chk("rst_wr_ignored", 0, 32'd0);
        chk("rst_iss_ignored", 3, 32'd0);
        step; we0 = 1; wa0 = 5'd8; wd0 = 32'hBEEF;
        step; idle;
        chk("resume_wr", 0, 32'hBEEF);

        @(negedge clk);
        #1;
        if (kind_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d pending expected 0", kind_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
